// File: rtl/sda_gmem_responder.sv
// sda_gmem_responder: AXI4 slave backed by a word-addressed on-chip memory.
// Ports: ap_clk/ap_rst_n, s_axi_gmem AW/W/B/AR/R channels; one burst per direction.
module sda_gmem_responder #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 1,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_gmem_AWADDR,
    input  logic [7:0]                  s_axi_gmem_AWLEN,
    input  logic [2:0]                  s_axi_gmem_AWSIZE,
    input  logic [1:0]                  s_axi_gmem_AWBURST,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_gmem_AWID,
    input  logic                        s_axi_gmem_AWVALID,
    output logic                        s_axi_gmem_AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_gmem_WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_gmem_WSTRB,
    input  logic                        s_axi_gmem_WLAST,
    input  logic                        s_axi_gmem_WVALID,
    output logic                        s_axi_gmem_WREADY,
    output logic [1:0]                  s_axi_gmem_BRESP,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_gmem_BID,
    output logic                        s_axi_gmem_BVALID,
    input  logic                        s_axi_gmem_BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_gmem_ARADDR,
    input  logic [7:0]                  s_axi_gmem_ARLEN,
    input  logic [2:0]                  s_axi_gmem_ARSIZE,
    input  logic [1:0]                  s_axi_gmem_ARBURST,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_gmem_ARID,
    input  logic                        s_axi_gmem_ARVALID,
    output logic                        s_axi_gmem_ARREADY,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_gmem_RDATA,
    output logic [1:0]                  s_axi_gmem_RRESP,
    output logic                        s_axi_gmem_RLAST,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_gmem_RID,
    output logic                        s_axi_gmem_RVALID,
    input  logic                        s_axi_gmem_RREADY
);

    localparam int NB    = AXI_DATA_WIDTH / 8;
    localparam int LB    = $clog2(NB);
    localparam int HI    = MEM_ADDR_WIDTH + LB;
    localparam int DEPTH = 2 ** MEM_ADDR_WIDTH;

    typedef logic [MEM_ADDR_WIDTH-1:0] idx_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    function automatic logic [1:0] chk(input logic [AXI_ADDR_WIDTH-1:0] a,
                                       input logic [2:0] size,
                                       input logic [1:0] burst);
        if ((a >> HI) != '0) return 2'b11;
        if (burst[1] || size != 3'(LB)) return 2'b10;
        return 2'b00;
    endfunction

    w_state_t w_st, w_nxt;
    r_state_t r_st, r_nxt;

    // Held low until the first edge after reset release so the
    // address channels stay quiet while in reset.
    logic run;

    logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];
    logic [AXI_DATA_WIDTH-1:0] rd_q;

    idx_t                    w_idx, r_idx, r_idx_nxt;
    logic [7:0]              w_len, w_cnt, r_len, r_cnt;
    logic [AXI_ID_WIDTH-1:0] w_id, r_id;
    logic [1:0]              w_err, r_err;
    logic                    w_fixed, r_fixed, w_mis;
    logic                    w_last, r_last, aw_hs, w_hs, ar_hs, r_hs;
    logic                    re;
    idx_t                    ra;

    assign w_last    = (w_cnt == w_len);
    assign r_last    = (r_cnt == r_len);
    assign aw_hs     = s_axi_gmem_AWVALID && s_axi_gmem_AWREADY;
    assign w_hs      = s_axi_gmem_WVALID && s_axi_gmem_WREADY;
    assign ar_hs     = s_axi_gmem_ARVALID && s_axi_gmem_ARREADY;
    assign r_hs      = s_axi_gmem_RVALID && s_axi_gmem_RREADY;
    assign r_idx_nxt = r_fixed ? r_idx : r_idx + MEM_ADDR_WIDTH'(1);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            run  <= 1'b0;
            w_st <= W_IDLE;
            r_st <= R_IDLE;
        end else begin
            run  <= 1'b1;
            w_st <= w_nxt;
            r_st <= r_nxt;
        end
    end

    always_comb begin
        w_nxt              = w_st;
        s_axi_gmem_AWREADY = 1'b0;
        s_axi_gmem_WREADY  = 1'b0;
        s_axi_gmem_BVALID  = 1'b0;
        s_axi_gmem_BRESP   = 2'b00;
        s_axi_gmem_BID     = '0;
        unique case (w_st)
            W_IDLE: begin
                s_axi_gmem_AWREADY = run;
                if (s_axi_gmem_AWVALID && run) w_nxt = W_DATA;
            end
            W_DATA: begin
                s_axi_gmem_WREADY = 1'b1;
                if (s_axi_gmem_WVALID && w_last) w_nxt = W_RESP;
            end
            W_RESP: begin
                s_axi_gmem_BVALID = 1'b1;
                s_axi_gmem_BID    = w_id;
                s_axi_gmem_BRESP  = (w_err != 2'b00) ? w_err :
                                    (w_mis ? 2'b10 : 2'b00);
                if (s_axi_gmem_BREADY) w_nxt = W_IDLE;
            end
            default: w_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        r_nxt              = r_st;
        s_axi_gmem_ARREADY = 1'b0;
        s_axi_gmem_RVALID  = 1'b0;
        s_axi_gmem_RDATA   = '0;
        s_axi_gmem_RRESP   = 2'b00;
        s_axi_gmem_RLAST   = 1'b0;
        s_axi_gmem_RID     = '0;
        unique case (r_st)
            R_IDLE: begin
                s_axi_gmem_ARREADY = run;
                if (s_axi_gmem_ARVALID && run) r_nxt = R_FETCH;
            end
            R_FETCH: r_nxt = R_DATA;
            R_DATA: begin
                s_axi_gmem_RVALID = 1'b1;
                s_axi_gmem_RRESP  = r_err;
                s_axi_gmem_RLAST  = r_last;
                s_axi_gmem_RID    = r_id;
                if (r_err == 2'b00) s_axi_gmem_RDATA = rd_q;
                if (s_axi_gmem_RREADY && r_last) r_nxt = R_IDLE;
            end
            default: r_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            w_idx   <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_id    <= '0;
            w_err   <= 2'b00;
            w_fixed <= 1'b0;
            w_mis   <= 1'b0;
        end else if (aw_hs) begin
            w_idx   <= s_axi_gmem_AWADDR[HI-1:LB];
            w_len   <= s_axi_gmem_AWLEN;
            w_cnt   <= '0;
            w_id    <= s_axi_gmem_AWID;
            w_err   <= chk(s_axi_gmem_AWADDR, s_axi_gmem_AWSIZE,
                           s_axi_gmem_AWBURST);
            w_fixed <= (s_axi_gmem_AWBURST == 2'b00);
            w_mis   <= 1'b0;
        end else if (w_hs) begin
            w_cnt <= w_cnt + 8'd1;
            if (!w_fixed) w_idx <= w_idx + MEM_ADDR_WIDTH'(1);
            if (s_axi_gmem_WLAST != w_last) w_mis <= 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_idx   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_id    <= '0;
            r_err   <= 2'b00;
            r_fixed <= 1'b0;
        end else if (ar_hs) begin
            r_idx   <= s_axi_gmem_ARADDR[HI-1:LB];
            r_len   <= s_axi_gmem_ARLEN;
            r_cnt   <= '0;
            r_id    <= s_axi_gmem_ARID;
            r_err   <= chk(s_axi_gmem_ARADDR, s_axi_gmem_ARSIZE,
                           s_axi_gmem_ARBURST);
            r_fixed <= (s_axi_gmem_ARBURST == 2'b00);
        end else if (r_hs && !r_last) begin
            r_cnt <= r_cnt + 8'd1;
            r_idx <= r_idx_nxt;
        end
    end

    // rd_q only moves on a fetch or an accepted non-final beat, which
    // keeps RDATA stable under backpressure.
    assign re = (r_st == R_FETCH) || (r_st == R_DATA && r_hs && !r_last);
    assign ra = (r_st == R_FETCH) ? r_idx : r_idx_nxt;

    // Memory is not reset. Read and write share one clocked block, so a
    // same-cycle access to one word returns the pre-write contents.
    always_ff @(posedge ap_clk) begin
        if (re) rd_q <= mem[ra];
        if (w_hs && w_err == 2'b00) begin
            for (int b = 0; b < NB; b++) begin
                if (s_axi_gmem_WSTRB[b])
                    mem[w_idx][b*8 +: 8] <= s_axi_gmem_WDATA[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_sda_gmem_responder.sv
// tb_sda_gmem_responder: directed self-checking bench for sda_gmem_responder.
// Drives/samples on the falling edge; one task per scenario.
module tb_sda_gmem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] AWADDR = '0;
    logic [7:0]  AWLEN = '0;
    logic [2:0]  AWSIZE = '0;
    logic [1:0]  AWBURST = '0;
    logic [0:0]  AWID = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WLAST = 1'b0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic [0:0]  BID;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [63:0] ARADDR = '0;
    logic [7:0]  ARLEN = '0;
    logic [2:0]  ARSIZE = '0;
    logic [1:0]  ARBURST = '0;
    logic [0:0]  ARID = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic [0:0]  RID;
    logic        RVALID;
    logic        RREADY = 1'b0;

    int total = 0;
    int bad = 0;

    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] rq_data [32];
    logic [63:0] rq_resp;
    logic [31:0] rq_last;
    logic [0:0]  rq_id;
    int          rq_n, rq_lat, rq_stall_err;
    logic [1:0]  wr_resp;
    logic [0:0]  wr_id;

    always #5 clk = ~clk;

    sda_gmem_responder dut (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .s_axi_gmem_AWADDR(AWADDR), .s_axi_gmem_AWLEN(AWLEN),
        .s_axi_gmem_AWSIZE(AWSIZE), .s_axi_gmem_AWBURST(AWBURST),
        .s_axi_gmem_AWID(AWID), .s_axi_gmem_AWVALID(AWVALID),
        .s_axi_gmem_AWREADY(AWREADY),
        .s_axi_gmem_WDATA(WDATA), .s_axi_gmem_WSTRB(WSTRB),
        .s_axi_gmem_WLAST(WLAST), .s_axi_gmem_WVALID(WVALID),
        .s_axi_gmem_WREADY(WREADY),
        .s_axi_gmem_BRESP(BRESP), .s_axi_gmem_BID(BID),
        .s_axi_gmem_BVALID(BVALID), .s_axi_gmem_BREADY(BREADY),
        .s_axi_gmem_ARADDR(ARADDR), .s_axi_gmem_ARLEN(ARLEN),
        .s_axi_gmem_ARSIZE(ARSIZE), .s_axi_gmem_ARBURST(ARBURST),
        .s_axi_gmem_ARID(ARID), .s_axi_gmem_ARVALID(ARVALID),
        .s_axi_gmem_ARREADY(ARREADY),
        .s_axi_gmem_RDATA(RDATA), .s_axi_gmem_RRESP(RRESP),
        .s_axi_gmem_RLAST(RLAST), .s_axi_gmem_RID(RID),
        .s_axi_gmem_RVALID(RVALID), .s_axi_gmem_RREADY(RREADY)
    );

    task automatic do_write(input logic [63:0] a, input logic [7:0] len,
                            input logic [1:0] bu, input int wlast_at,
                            input bit rnd, input logic [0:0] id);
        int n;
        @(negedge clk);
        AWADDR = a; AWLEN = len; AWSIZE = 3'd2; AWBURST = bu; AWID = id;
        AWVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < 50) begin @(negedge clk); n++; end
        if (!AWREADY) begin
            total++; bad++; $display("FAIL aw_timeout");
        end
        @(negedge clk);
        AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            WDATA = wd[i]; WSTRB = ws[i]; WLAST = (i == wlast_at);
            WVALID = 1'b1;
            n = 0;
            while (!WREADY && n < 50) begin @(negedge clk); n++; end
            @(negedge clk);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        n = 0;
        BREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        while (!(BVALID && BREADY) && n < 100) begin
            @(negedge clk); n++;
            BREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        wr_resp = BRESP; wr_id = BID;
        if (!(BVALID && BREADY)) begin
            total++; bad++; $display("FAIL b_timeout");
        end
        @(negedge clk);
        BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [63:0] a, input logic [7:0] len,
                           input logic [1:0] bu, input logic [2:0] sz,
                           input bit rnd, input logic [0:0] id);
        int n;
        bit done, stall;
        logic [34:0] prev;
        rq_n = 0; rq_lat = -1; rq_stall_err = 0;
        rq_resp = '0; rq_last = '0; rq_id = '0;
        @(negedge clk);
        ARADDR = a; ARLEN = len; ARSIZE = sz; ARBURST = bu; ARID = id;
        ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 50) begin @(negedge clk); n++; end
        if (!ARREADY) begin
            total++; bad++; $display("FAIL ar_timeout");
        end
        @(negedge clk);
        ARVALID = 1'b0;
        n = 1; done = 0; stall = 0; prev = '0;
        while (!done && n < 300) begin
            RREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (RVALID) begin
                if (rq_lat < 0) rq_lat = n;
                if (stall && {RDATA, RLAST, RRESP} !== prev) rq_stall_err++;
                if (RREADY) begin
                    if (rq_n < 32) begin
                        rq_data[rq_n] = RDATA;
                        rq_resp[rq_n*2 +: 2] = RRESP;
                        rq_last[rq_n] = RLAST;
                    end
                    rq_id = RID;
                    rq_n++;
                    if (RLAST) done = 1;
                    stall = 0;
                end else begin
                    stall = 1;
                    prev = {RDATA, RLAST, RRESP};
                end
            end
            @(negedge clk); n++;
        end
        RREADY = 1'b0;
        if (!done) begin
            total++; bad++; $display("FAIL r_timeout");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST, RDATA, BRESP,
             RRESP} !== '0) begin
            bad++; $display("FAIL reset_outputs got=%h", {AWREADY, ARREADY,
                WREADY, BVALID, RVALID, RLAST, RDATA, BRESP, RRESP});
        end
        rst_n = 1'b1;
        #1;
        total++;
        if ({AWREADY, ARREADY} !== 2'b00) begin
            bad++; $display("FAIL ready_before_edge got=%b want=00",
                            {AWREADY, ARREADY});
        end
        @(negedge clk);
        total++;
        if ({AWREADY, ARREADY} !== 2'b11) begin
            bad++; $display("FAIL ready_after_edge got=%b want=11",
                            {AWREADY, ARREADY});
        end
    endtask

    task automatic test_write_read();
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        do_write(64'h40, 8'd3, 2'b01, 3, 0, 1'b1);
        total++;
        if ({wr_resp, wr_id} !== 3'b001) begin
            bad++; $display("FAIL wr_bresp got=%b want=001", {wr_resp, wr_id});
        end
        do_read(64'h40, 8'd3, 2'b01, 3'd2, 0, 1'b1);
        total++;
        if ({rq_data[0], rq_data[1], rq_data[2], rq_data[3]} !==
            {32'd1, 32'd2, 32'd3, 32'd4}) begin
            bad++; $display("FAIL wr_rdata got=%h %h %h %h want=1 2 3 4",
                rq_data[0], rq_data[1], rq_data[2], rq_data[3]);
        end
        total++;
        if ({rq_n, rq_last[3:0], rq_resp[7:0], rq_id} !==
            {32'd4, 4'b1000, 8'h00, 1'b1}) begin
            bad++; $display("FAIL wr_rmeta got n=%0d last=%b resp=%h id=%b",
                rq_n, rq_last[3:0], rq_resp[7:0], rq_id);
        end
        total++;
        if (rq_lat !== 2) begin
            bad++; $display("FAIL r_latency got=%0d want=2", rq_lat);
        end
    endtask

    task automatic test_strobe_fixed();
        wd[0] = 32'hAABBCCDD; ws[0] = 4'hF;
        do_write(64'h10, 8'd0, 2'b01, 0, 0, 1'b0);
        wd[0] = 32'h11; ws[0] = 4'h1;
        wd[1] = 32'h2200; ws[1] = 4'h2;
        do_write(64'h10, 8'd1, 2'b00, 1, 0, 1'b0);
        total++;
        if (wr_resp !== 2'b00) begin
            bad++; $display("FAIL fixed_bresp got=%b want=00", wr_resp);
        end
        do_read(64'h10, 8'd0, 2'b01, 3'd2, 0, 1'b0);
        total++;
        if (rq_data[0] !== 32'hAABB2211) begin
            bad++; $display("FAIL strobe_data got=%h want=aabb2211",
                            rq_data[0]);
        end
    endtask

    task automatic test_wrap();
        wd[0] = 32'hCAFE0001; ws[0] = 4'hF;
        wd[1] = 32'hCAFE0002; ws[1] = 4'hF;
        do_write(64'hFFC, 8'd1, 2'b01, 1, 0, 1'b0);
        do_read(64'h0, 8'd0, 2'b01, 3'd2, 0, 1'b0);
        total++;
        if (rq_data[0] !== 32'hCAFE0002) begin
            bad++; $display("FAIL incr_wrap got=%h want=cafe0002", rq_data[0]);
        end
    endtask

    task automatic test_errors();
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hDEAD0000; ws[i] = 4'hF; end
        do_write(64'h100040, 8'd3, 2'b01, 3, 0, 1'b0);
        total++;
        if (wr_resp !== 2'b11) begin
            bad++; $display("FAIL decerr_bresp got=%b want=11", wr_resp);
        end
        do_read(64'h40, 8'd3, 2'b01, 3'd2, 0, 1'b0);
        total++;
        if ({rq_data[0], rq_data[1], rq_data[2], rq_data[3]} !==
            {32'd1, 32'd2, 32'd3, 32'd4}) begin
            bad++; $display("FAIL decerr_mem got=%h %h %h %h want=1 2 3 4",
                rq_data[0], rq_data[1], rq_data[2], rq_data[3]);
        end
        do_read(64'h40, 8'd3, 2'b10, 3'd2, 0, 1'b0);
        total++;
        if ({rq_n, rq_resp[7:0], rq_last[3:0], rq_data[0] | rq_data[1] |
             rq_data[2] | rq_data[3]} !== {32'd4, 8'hAA, 4'b1000, 32'd0}) begin
            bad++; $display("FAIL slverr_read got n=%0d resp=%h last=%b d0=%h",
                rq_n, rq_resp[7:0], rq_last[3:0], rq_data[0]);
        end
        do_read(64'h40, 8'd0, 2'b01, 3'd1, 0, 1'b0);
        total++;
        if ({rq_resp[1:0], rq_data[0]} !== {2'b10, 32'd0}) begin
            bad++; $display("FAIL size_err got resp=%b data=%h",
                rq_resp[1:0], rq_data[0]);
        end
        do_read(64'h8000000000000040, 8'd0, 2'b10, 3'd1, 0, 1'b0);
        total++;
        if (rq_resp[1:0] !== 2'b11) begin
            bad++; $display("FAIL decerr_prio got=%b want=11", rq_resp[1:0]);
        end
    endtask

    task automatic test_wlast_mismatch();
        wd[0] = 32'h7; wd[1] = 32'h8; wd[2] = 32'h9;
        ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF;
        do_write(64'h80, 8'd2, 2'b01, 1, 0, 1'b0);
        total++;
        if (wr_resp !== 2'b10) begin
            bad++; $display("FAIL wlast_bresp got=%b want=10", wr_resp);
        end
        do_read(64'h80, 8'd2, 2'b01, 3'd2, 0, 1'b0);
        total++;
        if ({rq_data[0], rq_data[1], rq_data[2]} !== {32'h7, 32'h8, 32'h9})
        begin
            bad++; $display("FAIL wlast_data got=%h %h %h want=7 8 9",
                rq_data[0], rq_data[1], rq_data[2]);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        for (int i = 0; i < 16; i++) begin
            wd[i] = 32'h5A000000 + 32'(i * 3); ws[i] = 4'hF;
        end
        do_write(64'h200, 8'd15, 2'b01, 15, 1, 1'b0);
        total++;
        if (wr_resp !== 2'b00) begin
            bad++; $display("FAIL bp_bresp got=%b want=00", wr_resp);
        end
        do_read(64'h200, 8'd15, 2'b01, 3'd2, 1, 1'b0);
        ok = (rq_n == 16) && (rq_last[15:0] == 16'h8000);
        for (int i = 0; i < 16; i++)
            if (rq_data[i] !== 32'h5A000000 + 32'(i * 3)) ok = 0;
        total++;
        if (!ok) begin
            bad++; $display("FAIL bp_beats got n=%0d last=%h d0=%h d15=%h",
                rq_n, rq_last[15:0], rq_data[0], rq_data[15]);
        end
        total++;
        if (rq_stall_err !== 0) begin
            bad++; $display("FAIL bp_stable got=%0d want=0", rq_stall_err);
        end
    endtask

    task automatic test_collision();
        logic [31:0] got;
        logic        bseen;
        @(negedge clk);
        AWADDR = 64'h40; AWLEN = 8'd0; AWSIZE = 3'd2; AWBURST = 2'b01;
        ARADDR = 64'h40; ARLEN = 8'd0; ARSIZE = 3'd2; ARBURST = 2'b01;
        AWVALID = 1'b1; ARVALID = 1'b1;
        @(negedge clk);
        AWVALID = 1'b0; ARVALID = 1'b0;
        WDATA = 32'h99; WSTRB = 4'hF; WLAST = 1'b1; WVALID = 1'b1;
        @(negedge clk);
        WVALID = 1'b0; WLAST = 1'b0;
        got = RDATA; bseen = BVALID;
        RREADY = 1'b1; BREADY = 1'b1;
        @(negedge clk);
        RREADY = 1'b0; BREADY = 1'b0;
        total++;
        if ({got, bseen} !== {32'h1, 1'b1}) begin
            bad++; $display("FAIL collision got=%h b=%b want=1 b=1",
                            got, bseen);
        end
        do_read(64'h40, 8'd0, 2'b01, 3'd2, 0, 1'b0);
        total++;
        if (rq_data[0] !== 32'h99) begin
            bad++; $display("FAIL collision_after got=%h want=99", rq_data[0]);
        end
        wd[0] = 32'h1; ws[0] = 4'hF;
        do_write(64'h40, 8'd0, 2'b01, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        ARADDR = 64'h40; ARLEN = 8'd7; ARSIZE = 3'd2; ARBURST = 2'b01;
        ARVALID = 1'b1;
        @(negedge clk);
        ARVALID = 1'b0;
        repeat (2) @(negedge clk);
        RREADY = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST, RDATA,
             RRESP} !== '0) begin
            bad++; $display("FAIL midrst_outputs rv=%b rd=%h ar=%b",
                            RVALID, RDATA, ARREADY);
        end
        RREADY = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (ARREADY !== 1'b0) begin
            bad++; $display("FAIL midrst_early got=%b want=0", ARREADY);
        end
        @(negedge clk);
        total++;
        if (ARREADY !== 1'b1) begin
            bad++; $display("FAIL midrst_arready got=%b want=1", ARREADY);
        end
        do_read(64'h40, 8'd3, 2'b01, 3'd2, 0, 1'b0);
        total++;
        if ({rq_data[0], rq_data[1], rq_data[2], rq_data[3]} !==
            {32'd1, 32'd2, 32'd3, 32'd4}) begin
            bad++; $display("FAIL midrst_mem got=%h %h %h %h want=1 2 3 4",
                rq_data[0], rq_data[1], rq_data[2], rq_data[3]);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_strobe_fixed();
        test_wrap();
        test_errors();
        test_wlast_mismatch();
        test_back_to_back();
        test_collision();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sda_gmem_responder.md
# sda_gmem_responder

AXI4 slave that responds to the kernel's `m_axi_gmem` master port. It is backed by a word-addressed on-chip memory, so kernel wrappers can be simulated and board-tested without the SDAccel shell's DDR controller. It sits at the far end of the gmem master interface and is instantiated by the test harness in place of the platform memory subsystem. Read and write channels are independent, with one outstanding burst per direction.

## Interface
- `AXI_ADDR_WIDTH`, 64, gmem address width in bits.
- `AXI_DATA_WIDTH`, 32, data width in bits; must be a power of two, 32 or more.
- `AXI_ID_WIDTH`, 1, ID width in bits.
- `MEM_ADDR_WIDTH`, 10, log2 of the memory depth in words.
- `ap_clk`  in  1  single clock; all logic on its rising edge.
- `ap_rst_n`  in  1  reset; asynchronous assert, active-low.
- `s_axi_gmem_AWADDR/AWLEN/AWSIZE/AWBURST/AWID`  in  ADDR/8/3/2/ID  write address fields.
- `s_axi_gmem_AWVALID`  in  1 / `s_axi_gmem_AWREADY`  out  1  write address handshake.
- `s_axi_gmem_WDATA/WSTRB/WLAST`  in  DATA/DATA/8/1  write data fields.
- `s_axi_gmem_WVALID`  in  1 / `s_axi_gmem_WREADY`  out  1  write data handshake.
- `s_axi_gmem_BRESP/BID`  out  2/ID  write response fields.
- `s_axi_gmem_BVALID`  out  1 / `s_axi_gmem_BREADY`  in  1  write response handshake.
- `s_axi_gmem_ARADDR/ARLEN/ARSIZE/ARBURST/ARID`  in  ADDR/8/3/2/ID  read address fields.
- `s_axi_gmem_ARVALID`  in  1 / `s_axi_gmem_ARREADY`  out  1  read address handshake.
- `s_axi_gmem_RDATA/RRESP/RLAST/RID`  out  DATA/2/1/ID  read data fields.
- `s_axi_gmem_RVALID`  out  1 / `s_axi_gmem_RREADY`  in  1  read data handshake.
- LOCK, CACHE, PROT, QOS, REGION and USER are not ports; the harness leaves them unconnected.

## Operation
- **Word size and index.**
  - B = `AXI_DATA_WIDTH`/8 bytes per word.
  - Word index = `ADDR[MEM_ADDR_WIDTH+log2(B)-1 : log2(B)]`. Low address bits are ignored, so transfers are always aligned.
- **Burst checks**, made at address handshake:
  - DECERR (2'b11) if any address bit at or above `MEM_ADDR_WIDTH+log2(B)` is set.
  - Otherwise SLVERR (2'b10) if BURST is neither FIXED (00) nor INCR (01), or if SIZE ≠ log2(B).
  - Otherwise OKAY (00).
  - DECERR takes priority over SLVERR.
- **Index update per beat.**
  - INCR: index+1, wrapping modulo 2^`MEM_ADDR_WIDTH`.
  - FIXED: index unchanged.
- **Write FSM: W_IDLE → W_DATA → W_RESP → W_IDLE.**
  - W_IDLE: AWREADY=1. On AW handshake, latch index, LEN, ID and error status, then go to W_DATA.
  - W_DATA: WREADY=1. Each W handshake writes the bytes with WSTRB=1, and only when status is OKAY. Beat counter runs 0..LEN. The beat with count LEN ends the burst and goes to W_RESP.
  - WLAST mismatch (WLAST high before the final beat, or low on it): set SLVERR (unless already DECERR). The burst length is still taken from LEN, and later beats are still written.
  - W_RESP: BVALID=1 with BRESP and BID. Hold until BREADY, then return to W_IDLE.
- **Read FSM: R_IDLE → R_FETCH → R_DATA → R_IDLE.**
  - R_IDLE: ARREADY=1. On AR handshake, latch index, LEN, ID and status, then go to R_FETCH.
  - R_FETCH: issue the synchronous memory read, then go to R_DATA.
  - R_DATA: RVALID=1, with RRESP = latched status and RID = latched ID.
  - RDATA is memory data when status is OKAY, otherwise zero.
  - RLAST=1 only on beat LEN.
  - On an R handshake that is not the last beat, the next index is read in the same cycle, so RVALID stays high.
  - RDATA/RRESP/RLAST are held stable while RVALID=1 and RREADY=0.
  - An R handshake on the last beat returns the FSM to R_IDLE.
- **Read/write collision.** A same-cycle write and read to the same word is read-first: the read returns the old data.
- **Reset.**
  - All outputs are 0 while `ap_rst_n`=0; both FSMs are in their IDLE states.
  - AWREADY/ARREADY assert on the first rising edge after reset release.
  - Reset mid-burst aborts the burst with no response. Memory contents are retained.

## Timing
- AW handshake at edge N → WREADY=1 from N+1.
- Final W handshake at edge M → BVALID=1 from M+1.
- AR handshake at edge N → RVALID=1 from N+2.
- With RREADY held high, a burst of LEN+1 beats completes on edges N+2..N+2+LEN.
- AWREADY is 0 from the AW handshake until the B handshake; ARREADY is 0 from the AR handshake until the last-beat R handshake.
- WREADY is 0 outside W_DATA; W beats presented early are stalled, not dropped.

## Test plan
- **Write then read.** INCR write, AWADDR=0x40, AWLEN=3, data 1..4, full WSTRB; then read back the same range. Expect BRESP=00; RDATA 1,2,3,4 with RLAST on beat 3; RVALID first asserts 2 cycles after the AR handshake.
- **Strobes and FIXED burst.** Write 0xAABBCCDD to 0x10; then a FIXED burst to 0x10, LEN=1, WSTRB=0x1 then 0x2, data 0x11 then 0x2200. Expect readback 0xAABB2211.
- **Errors.** AWADDR bit 20 set (`MEM_ADDR_WIDTH`=10) → BRESP=11 and memory unchanged. ARBURST=2'b10 → RRESP=10, RDATA=0, four beats for ARLEN=3.
- **WLAST mismatch.** AWLEN=2 with WLAST on beat 1 → BRESP=10; all three beats still consumed and written.
- **Backpressure.** Random RREADY/BREADY stalls over a 16-beat read. Expect RDATA stable during stalls and no lost or duplicated beats. Concurrent write and read to the same word returns the old data.
- **Reset mid-operation.** Assert `ap_rst_n`=0 mid read burst. Expect all outputs 0 immediately (asynchronously); ARREADY=1 one edge after release; memory data intact on re-read.
